fetch_pfb: RTL and testbench

- Parametrised successor of the single-entry fetch stage, placed between imem_ctrl and dec.
- Decouples instruction fetch from decode with a DEPTH-entry first-word-fall-through prefetch buffer.
- Supports multiple outstanding pipelined imem requests and discards stale responses after a redirect.
- Accepts one unified, already-prioritised redirect (trap/mret/branch/jal/jalr merged upstream) and reports misaligned targets.

---
 rtl/fetch_pfb.sv | 135 +++++++++++++
 tb/tb_fetch_pfb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pfb.sv
// Prefetch buffer between imem_ctrl and dec. It keeps several imem requests in
// flight, holds the returned instructions in a FWFT buffer, and drops stale ones after a redirect.
module fetch_pfb #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]  boot_addr,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_req,
  output logic [ADDR_WIDTH-1:0]  instr_addr,
  input  logic                   instr_gnt,
  input  logic                   instr_rvalid,
  input  logic [INSTR_WIDTH-1:0] instr_rdata,
  output logic                   if_valid,
  input  logic                   dec_ready,
  output logic [INSTR_WIDTH-1:0] instr_dec,
  output logic [ADDR_WIDTH-1:0]  pc_dec,
  output logic                   pc_misaligned,
  output logic [ADDR_WIDTH-1:0]  fault_pc,
  output logic [CW-1:0]          fifo_level
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  resp_pc_q, resp_pc_d;
  logic [ADDR_WIDTH-1:0]  fault_pc_q, fault_pc_d;
  logic [CW-1:0]          level_q, level_d;
  logic [CW-1:0]          outst_q, outst_d;
  logic [CW-1:0]          discard_q, discard_d;
  logic [INSTR_WIDTH-1:0] ins_q [DEPTH];
  logic [INSTR_WIDTH-1:0] ins_d [DEPTH];
  logic [ADDR_WIDTH-1:0]  pcs_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  pcs_d [DEPTH];

  logic [CW:0]   inflight;
  logic          req, accept, resp_ok, push, pop;
  logic [CW-1:0] wr_idx;

  // Buffered plus in-flight entries never exceed DEPTH, so a push always has room.
  assign inflight = {1'b0, level_q} + {1'b0, outst_q};
  assign req      = cpu_rstn && (state_q == RUN) && !redirect_valid &&
                    (inflight < (CW+1)'(DEPTH));
  assign accept   = req && instr_gnt;
  assign resp_ok  = instr_rvalid && (outst_q != '0);
  assign push     = resp_ok && (discard_q == '0) && !redirect_valid;
  assign pop      = (level_q != '0) && dec_ready && !redirect_valid;
  assign wr_idx   = pop ? level_q - CW'(1) : level_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    fault_pc_d = fault_pc_q;
    level_d    = level_q;
    discard_d  = discard_q;
    ins_d      = ins_q;
    pcs_d      = pcs_q;
    outst_d    = outst_q + CW'(accept) - CW'(resp_ok);

    if (redirect_valid) begin
      discard_d  = outst_q - CW'(resp_ok);
      level_d    = '0;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = FAULT;
        fault_pc_d = redirect_pc;
      end else begin
        state_d    = RUN;
        fault_pc_d = '0;
      end
    end else begin
      if (resp_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (accept) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      if (push)   resp_pc_d  = resp_pc_q + ADDR_WIDTH'(4);
      level_d = level_q + CW'(push) - CW'(pop);
      // Entry 0 is the head; a pop shifts everything one slot toward it.
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (pop) begin
          ins_d[i] = ins_q[i+1];
          pcs_d[i] = pcs_q[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CW'(i))) begin
          ins_d[i] = instr_rdata;
          pcs_d[i] = resp_pc_q;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state_q    <= RUN;
      fetch_pc_q <= boot_addr;
      resp_pc_q  <= boot_addr;
      fault_pc_q <= '0;
      level_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pcs_q[i] <= boot_addr;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      fault_pc_q <= fault_pc_d;
      level_q    <= level_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      ins_q      <= ins_d;
      pcs_q      <= pcs_d;
    end
  end

  assign instr_addr    = fetch_pc_q;
  assign instr_req     = req;
  assign if_valid      = (level_q != '0);
  assign instr_dec     = ins_q[0];
  assign pc_dec        = pcs_q[0];
  assign pc_misaligned = (state_q == FAULT);
  assign fault_pc      = fault_pc_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_fetch_pfb.sv
// Randomized bench for fetch_pfb: an in-order imem model feeds a queue-based
// scoreboard of the prefetch buffer contents, request bound and fault state.
module tb_fetch_pfb;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn;
  logic [AW-1:0] boot_addr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          instr_gnt;
  logic          instr_rvalid;
  logic [IW-1:0] instr_rdata;
  logic          if_valid;
  logic          dec_ready;
  logic [IW-1:0] instr_dec;
  logic [AW-1:0] pc_dec;
  logic          pc_misaligned;
  logic [AW-1:0] fault_pc;
  logic [CW-1:0] fifo_level;

  fetch_pfb #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .boot_addr(boot_addr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .if_valid(if_valid), .dec_ready(dec_ready), .instr_dec(instr_dec),
    .pc_dec(pc_dec), .pc_misaligned(pc_misaligned), .fault_pc(fault_pc),
    .fifo_level(fifo_level)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    bit            stale;
    bit            orphan;
  } req_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
  } ent_t;

  req_t          pend[$];
  ent_t          fifo[$];
  logic [AW-1:0] m_fetch;
  logic [AW-1:0] m_fault_pc;
  bit            m_fault;
  bit            just_reset;
  int            cyc, checks, errors;
  int            p_gnt, p_rdy, p_redir, p_mis, p_rv, lat_min, lat_max;

  function automatic logic [IW-1:0] mem_f(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", tag, act, exp, cyc);
    end
  endtask

  function automatic int n_live();
    int n = 0;
    foreach (pend[i]) if (!pend[i].orphan) n++;
    return n;
  endfunction

  task automatic step(input bit rst, input bit f_redir, input logic [AW-1:0] f_pc);
    bit            rv, redir, acc, exp_req, orph;
    logic [AW-1:0] rpc;
    req_t          h, n;
    ent_t          e;
    @(negedge cpu_clk);
    cyc++;
    orph  = (pend.size() != 0) && pend[0].orphan;
    redir = f_redir || (!rst && ($urandom_range(0, 99) < p_redir));
    rpc   = {14'h0, 16'($urandom), 2'b00};
    if ($urandom_range(0, 99) < p_mis) rpc[1:0] = 2'($urandom_range(1, 3));
    if (f_redir) rpc = f_pc;
    cpu_rstn       = !rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    dec_ready      = ($urandom_range(0, 99) < p_rdy);
    instr_gnt      = !orph && ($urandom_range(0, 99) < p_gnt);
    rv = (pend.size() != 0) && (pend[0].due <= cyc) && ($urandom_range(0, 99) < p_rv);
    instr_rvalid   = rv || ((pend.size() == 0) && ($urandom_range(0, 99) < 2));
    instr_rdata    = rv ? mem_f(pend[0].addr) : $urandom;
    #1;
    exp_req = !rst && !m_fault && !redir && ((fifo.size() + n_live()) < DEPTH);
    chk("instr_req", 32'(instr_req), 32'(exp_req));
    if (exp_req) chk("instr_addr", instr_addr, m_fetch);
    chk("fifo_level", 32'(fifo_level), 32'(fifo.size()));
    chk("if_valid", 32'(if_valid), 32'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      chk("pc_dec", pc_dec, fifo[0].pc);
      chk("instr_dec", instr_dec, fifo[0].ins);
    end
    if (just_reset) begin
      chk("rst_pc_dec", pc_dec, boot_addr);
      chk("rst_instr_dec", instr_dec, 32'h0);
    end
    chk("pc_misaligned", 32'(pc_misaligned), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fault_pc);

    acc = exp_req && instr_gnt;
    if (rst) begin
      if (rv) void'(pend.pop_front());
      foreach (pend[i]) pend[i].orphan = 1'b1;
      fifo.delete();
      m_fetch    = boot_addr;
      m_fault    = 1'b0;
      m_fault_pc = '0;
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (!redir && (fifo.size() != 0) && dec_ready) void'(fifo.pop_front());
      if (rv) begin
        h = pend.pop_front();
        if (!h.stale && !h.orphan && !redir) begin
          e.pc  = h.addr;
          e.ins = mem_f(h.addr);
          fifo.push_back(e);
        end
      end
      if (redir) begin
        fifo.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        m_fetch    = rpc;
        m_fault    = (rpc[1:0] != 2'b00);
        m_fault_pc = m_fault ? rpc : '0;
      end
      if (acc) begin
        n.addr   = m_fetch;
        n.due    = cyc + $urandom_range(lat_min, lat_max);
        n.stale  = 1'b0;
        n.orphan = 1'b0;
        pend.push_back(n);
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic knobs(input int g, input int r, input int rd, input int mi,
                       input int rvp, input int lmin, input int lmax);
    p_gnt = g; p_rdy = r; p_redir = rd; p_mis = mi; p_rv = rvp;
    lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    boot_addr = 32'h100; cpu_rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_gnt = 1'b0; instr_rvalid = 1'b0; instr_rdata = '0; dec_ready = 1'b0;
    m_fetch = 32'h100; m_fault = 1'b0; m_fault_pc = '0; just_reset = 1'b1;
    knobs(100, 100, 0, 0, 100, 1, 1);
    repeat (2) @(posedge cpu_clk);
    step(1'b1, 1'b0, '0);

    // boot at 0x100, full rate
    run(20);
    // backpressure until the bound is hit, then release
    knobs(100, 0, 0, 0, 100, 1, 1);
    run(12);
    chk("bp_level_sat", 32'(fifo_level), 32'(DEPTH));
    knobs(100, 100, 0, 0, 100, 1, 1);
    run(10);
    // redirect with several outstanding at 4-cycle latency
    knobs(100, 100, 0, 0, 100, 4, 4);
    run(10);
    step(1'b0, 1'b1, 32'h2000);
    run(15);
    // redirect hitting a response and a pop in the same cycle
    knobs(100, 100, 0, 0, 100, 2, 2);
    run(10);
    step(1'b0, 1'b1, 32'h3000);
    run(10);
    // misaligned target, then recovery at 0x80
    step(1'b0, 1'b1, 32'h2002);
    run(6);
    step(1'b0, 1'b1, 32'h2007);
    run(3);
    step(1'b0, 1'b1, 32'h80);
    run(12);
    // reset with a partly filled buffer and requests in flight
    knobs(100, 0, 0, 0, 100, 3, 3);
    run(4);
    boot_addr = 32'h400;
    step(1'b1, 1'b0, '0);
    knobs(100, 100, 0, 0, 100, 1, 3);
    run(15);
    // address wrap
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    run(12);
    // random mix
    for (int blk = 0; blk < 30; blk++) begin
      knobs($urandom_range(20, 100), $urandom_range(0, 100), $urandom_range(0, 8),
            $urandom_range(0, 20), $urandom_range(40, 100), 1, $urandom_range(1, 5));
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          boot_addr = {14'h0, 16'($urandom), 2'b00};
          step(1'b1, 1'b0, '0);
        end else begin
          step(1'b0, 1'b0, '0);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
